// File: rtl/lc_pkg.sv
// Shared types and helpers for the local-coincidence trigger generator.
// Contents: IDLE/HOLDOFF state type, record field widths, saturating increment.
// No logic; imported by lc_holdoff_timer and lc_trigger_gen.
package lc_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    HOLDOFF = 1'b1
  } lc_state_e;

  localparam int LC_SEQ_WIDTH = 16;
  localparam int LC_TS_WIDTH  = 48;

  // Widest counter the helper handles; callers zero-extend into it and
  // truncate the result back to their own width.
  localparam int LC_CNT_MAX_WIDTH = 64;

  // Increment that sticks at max instead of wrapping.
  function automatic logic [LC_CNT_MAX_WIDTH-1:0] lc_sat_inc(
    input logic [LC_CNT_MAX_WIDTH-1:0] val,
    input logic [LC_CNT_MAX_WIDTH-1:0] max
  );
    return (val >= max) ? val : val + LC_CNT_MAX_WIDTH'(1);
  endfunction

endpackage

// File: rtl/lc_holdoff_timer.sv
// Deadtime timer: load starts HOLDOFF with the counter at len; counts to 0, then IDLE.
// Latency: busy rises the cycle after load and lasts len+1 cycles.
// Backpressure: none; load is ignored unless IDLE.
// Ports: clk, reset_n, load, len -> busy (in HOLDOFF), done (last HOLDOFF cycle).
module lc_holdoff_timer
  import lc_pkg::*;
#(
  parameter int P_HOLDOFF_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       load,
  input  logic [P_HOLDOFF_WIDTH-1:0] len,
  output logic                       busy,
  output logic                       done
);

  lc_state_e                  state_q, state_d;
  logic [P_HOLDOFF_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = HOLDOFF;
          cnt_d   = len;
        end
      end
      HOLDOFF: begin
        // The cycle that sees 0 is still a HOLDOFF cycle, so len=0 gives one.
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - P_HOLDOFF_WIDTH'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == HOLDOFF);
  assign done = busy && (cnt_q == '0);

endmodule

// File: rtl/lc_trigger_gen.sv
// LC trigger generator: rising edge of masked coincidence -> lc_trig pulse, event record, holdoff.
// Latency: lc_trig/record appear one cycle after the qualifying edge.
// Backpressure: record held while evt_valid & !evt_ready; an edge arriving then is dropped and counted.
// Ports: clk, reset_n, enable, holdoff_len, chan_mask, local_coinc -> lc_trig, busy,
//        evt_valid/evt_ready/evt_mask/evt_seq, n_lc_events, n_lc_dropped.
// Optional: LC_TIMESTAMP_EN adds timestamp input and evt_ts record field.
module lc_trigger_gen
  import lc_pkg::*;
#(
  parameter int N_CHANNELS      = 24,
  parameter int P_HOLDOFF_WIDTH = 16,
  parameter int P_CNT_WIDTH     = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic [P_HOLDOFF_WIDTH-1:0] holdoff_len,
  input  logic [N_CHANNELS-1:0]      chan_mask,
  input  logic [N_CHANNELS-1:0]      local_coinc,
`ifdef LC_TIMESTAMP_EN
  input  logic [LC_TS_WIDTH-1:0]     timestamp,
  output logic [LC_TS_WIDTH-1:0]     evt_ts,
`endif
  output logic                       lc_trig,
  output logic                       busy,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [N_CHANNELS-1:0]      evt_mask,
  output logic [LC_SEQ_WIDTH-1:0]    evt_seq,
  output logic [P_CNT_WIDTH-1:0]     n_lc_events,
  output logic [P_CNT_WIDTH-1:0]     n_lc_dropped
);

  localparam logic [LC_CNT_MAX_WIDTH-1:0] CNT_MAX =
    LC_CNT_MAX_WIDTH'({P_CNT_WIDTH{1'b1}});

  logic [N_CHANNELS-1:0]   masked;
  logic                    any;
  logic                    any_prev_q;
  logic                    tmr_busy;
  logic                    tmr_done_unused;
  logic                    qual, slot_free, accept, drop;

  logic                    lc_trig_q;
  logic                    evt_valid_q;
  logic [N_CHANNELS-1:0]   evt_mask_q;
  logic [LC_SEQ_WIDTH-1:0] evt_seq_q;
  logic [LC_SEQ_WIDTH-1:0] seq_q;
  logic [P_CNT_WIDTH-1:0]  evt_cnt_q;
  logic [P_CNT_WIDTH-1:0]  drop_cnt_q;

  assign masked = local_coinc & chan_mask;
  assign any    = |masked;

  // Edges are judged against the previous cycle's level even during holdoff,
  // so a level held high across holdoff must fall and rise to retrigger.
  assign qual      = any & ~any_prev_q & enable & ~tmr_busy;
  assign slot_free = ~evt_valid_q | evt_ready;
  assign accept    = qual & slot_free;
  assign drop      = qual & ~slot_free;

  // Dropped edges still arm the deadtime.
  lc_holdoff_timer #(
    .P_HOLDOFF_WIDTH(P_HOLDOFF_WIDTH)
  ) u_holdoff (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (qual),
    .len    (holdoff_len),
    .busy   (tmr_busy),
    .done   (tmr_done_unused)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      any_prev_q  <= 1'b0;
      lc_trig_q   <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_mask_q  <= '0;
      evt_seq_q   <= '0;
      seq_q       <= '0;
      evt_cnt_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      any_prev_q <= any;
      lc_trig_q  <= accept;
      // A new accept wins over consumption so back-to-back records don't bubble.
      if (accept) begin
        evt_valid_q <= 1'b1;
        evt_mask_q  <= masked;
        evt_seq_q   <= seq_q;
        seq_q       <= seq_q + LC_SEQ_WIDTH'(1);
        evt_cnt_q   <= P_CNT_WIDTH'(lc_sat_inc(LC_CNT_MAX_WIDTH'(evt_cnt_q), CNT_MAX));
      end else if (evt_ready) begin
        evt_valid_q <= 1'b0;
      end
      if (drop) begin
        drop_cnt_q <= P_CNT_WIDTH'(lc_sat_inc(LC_CNT_MAX_WIDTH'(drop_cnt_q), CNT_MAX));
      end
    end
  end

`ifdef LC_TIMESTAMP_EN
  logic [LC_TS_WIDTH-1:0] evt_ts_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    evt_ts_q <= '0;
    else if (accept) evt_ts_q <= timestamp;
  end

  assign evt_ts = evt_ts_q;
`endif

  assign lc_trig      = lc_trig_q;
  assign busy         = tmr_busy;
  assign evt_valid    = evt_valid_q;
  assign evt_mask     = evt_mask_q;
  assign evt_seq      = evt_seq_q;
  assign n_lc_events  = evt_cnt_q;
  assign n_lc_dropped = drop_cnt_q;

endmodule

// File: tb/tb_lc_trigger_gen.sv
// Bench for lc_trigger_gen: records expected at stimulus time are queued and
// compared whenever the DUT's record is consumed (evt_valid & evt_ready).
// A second instance with 2-bit counters exercises saturation at all-ones.
module tb_lc_trigger_gen;
  import lc_pkg::*;

  localparam int NC = 24;

  logic          clk;
  logic          reset_n;
  logic          enable;
  logic [15:0]   holdoff_len;
  logic [NC-1:0] chan_mask;
  logic [NC-1:0] local_coinc;
  logic          evt_ready;

  logic          lc_trig, busy, evt_valid;
  logic [NC-1:0] evt_mask;
  logic [15:0]   evt_seq;
  logic [31:0]   n_lc_events, n_lc_dropped;

  logic          s_lc_trig, s_busy, s_evt_valid;
  logic [NC-1:0] s_evt_mask;
  logic [15:0]   s_evt_seq;
  logic [1:0]    s_events, s_dropped;

`ifdef LC_TIMESTAMP_EN
  logic [47:0]   timestamp, evt_ts, s_evt_ts;
  initial timestamp = '0;
  always @(posedge clk) timestamp <= timestamp + 48'd1;
`endif

  lc_trigger_gen dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .holdoff_len(holdoff_len),
    .chan_mask(chan_mask), .local_coinc(local_coinc),
`ifdef LC_TIMESTAMP_EN
    .timestamp(timestamp), .evt_ts(evt_ts),
`endif
    .lc_trig(lc_trig), .busy(busy), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_mask(evt_mask), .evt_seq(evt_seq),
    .n_lc_events(n_lc_events), .n_lc_dropped(n_lc_dropped)
  );

  lc_trigger_gen #(.P_CNT_WIDTH(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .enable(enable), .holdoff_len(holdoff_len),
    .chan_mask(chan_mask), .local_coinc(local_coinc),
`ifdef LC_TIMESTAMP_EN
    .timestamp(timestamp), .evt_ts(s_evt_ts),
`endif
    .lc_trig(s_lc_trig), .busy(s_busy), .evt_valid(s_evt_valid), .evt_ready(evt_ready),
    .evt_mask(s_evt_mask), .evt_seq(s_evt_seq),
    .n_lc_events(s_events), .n_lc_dropped(s_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NC-1:0] mask;
    logic [15:0]   seq;
  } exp_rec_t;

  exp_rec_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input logic [NC-1:0] mask, input logic [15:0] seq);
    exp_rec_t e;
    e.mask = mask;
    e.seq  = seq;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    sb.delete();
    tick(1);
  endtask

  // One-cycle coincidence pulse followed by two quiet cycles.
  task automatic pulse(input logic [NC-1:0] lc, input bit accepted, input logic [15:0] seq);
    local_coinc = lc;
    if (accepted) push_exp(lc & chan_mask, seq);
    tick(1);
    local_coinc = '0;
    tick(2);
  endtask

  // Scoreboard: every consumed record must match the oldest expected one.
  always @(negedge clk) begin
    if (reset_n && evt_valid && evt_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_record", 64'(evt_seq), 64'hFFFF_FFFF);
      end else begin
        exp_rec_t e;
        e = sb.pop_front();
        chk("sb_mask", 64'(evt_mask), 64'(e.mask));
        chk("sb_seq", 64'(evt_seq), 64'(e.seq));
      end
    end
  end

  function automatic logic [NC-1:0] t2_lc(input int c);
    case (c)
      0, 1, 2: return 24'h000001;
      5:       return 24'h000002;
      20:      return 24'h000004;
      default: return '0;
    endcase
  endfunction

  initial begin
    int bcount, tcount, t_at0, t_at1;

    reset_n     = 1'b0;
    enable      = 1'b1;
    holdoff_len = 16'd4;
    chan_mask   = '1;
    local_coinc = '0;
    evt_ready   = 1'b1;
    tick(2);
    chk("rst_lc_trig", 64'(lc_trig), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_evt_valid", 64'(evt_valid), 0);
    chk("rst_evt_seq", 64'(evt_seq), 0);
    chk("rst_n_lc_events", n_lc_events, 0);
    reset_n = 1'b1;
    tick(1);

    // 1: basic accept with 5-cycle busy window.
    holdoff_len = 16'd4;
    local_coinc = 24'h000088;
    push_exp(24'h000088, 16'd0);
    bcount = 0;
    tcount = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (i == 0) begin
        chk("t1_trig_t1", 64'(lc_trig), 1);
        chk("t1_mask", 64'(evt_mask), 64'h88);
        chk("t1_seq", 64'(evt_seq), 0);
      end
      if (busy) bcount++;
      if (lc_trig) tcount++;
    end
    chk("t1_busy_cycles", 64'(bcount), 5);
    chk("t1_trig_count", 64'(tcount), 1);
    chk("t1_events", n_lc_events, 1);
    local_coinc = '0;
    tick(2);

    // 2: edges inside holdoff are ignored.
    do_reset();
    holdoff_len = 16'd10;
    tcount = 0;
    t_at0  = -1;
    t_at1  = -1;
    for (int c = 0; c < 26; c++) begin
      local_coinc = t2_lc(c);
      if (c == 0)  push_exp(24'h000001, 16'd0);
      if (c == 20) push_exp(24'h000004, 16'd1);
      tick(1);
      if (lc_trig) begin
        if (tcount == 0) t_at0 = c + 1;
        else             t_at1 = c + 1;
        tcount++;
      end
    end
    chk("t2_trig_count", 64'(tcount), 2);
    chk("t2_first_at", 64'(t_at0), 1);
    chk("t2_second_at", 64'(t_at1), 21);
    chk("t2_dropped", n_lc_dropped, 0);
    chk("t2_events", n_lc_events, 2);

    // 3: backpressure drops.
    do_reset();
    holdoff_len = 16'd0;
    evt_ready   = 1'b0;
    tcount      = 0;
    local_coinc = 24'h000010;
    push_exp(24'h000010, 16'd0);
    tick(1);
    if (lc_trig) tcount++;
    local_coinc = '0;
    tick(3);
    local_coinc = 24'h000020;
    tick(1);
    if (lc_trig) tcount++;
    local_coinc = '0;
    tick(3);
    local_coinc = 24'h000040;
    tick(1);
    if (lc_trig) tcount++;
    local_coinc = '0;
    tick(3);
    chk("t3_trig_count", 64'(tcount), 1);
    chk("t3_held_seq", 64'(evt_seq), 0);
    chk("t3_held_mask", 64'(evt_mask), 64'h10);
    chk("t3_valid_held", 64'(evt_valid), 1);
    chk("t3_dropped", n_lc_dropped, 2);
    chk("t3_events", n_lc_events, 1);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    chk("t3_valid_cleared", 64'(evt_valid), 0);

    // 4: ready and new accept in the same cycle.
    do_reset();
    holdoff_len = 16'd0;
    evt_ready   = 1'b0;
    local_coinc = 24'h000001;
    push_exp(24'h000001, 16'd0);
    tick(1);
    local_coinc = '0;
    tick(2);
    local_coinc = 24'h000002;
    evt_ready   = 1'b1;
    push_exp(24'h000002, 16'd1);
    tick(1);
    evt_ready   = 1'b0;
    local_coinc = '0;
    chk("t4_valid_kept", 64'(evt_valid), 1);
    chk("t4_seq", 64'(evt_seq), 1);
    chk("t4_mask", 64'(evt_mask), 64'h2);
    chk("t4_dropped", n_lc_dropped, 0);
    chk("t4_events", n_lc_events, 2);
    tick(2);
    evt_ready = 1'b1;
    tick(1);
    chk("t4_valid_cleared", 64'(evt_valid), 0);

    // 5: masking and enable.
    do_reset();
    holdoff_len = 16'd4;
    chan_mask   = 24'h000001;
    pulse(24'h000020, 1'b0, 16'd0);
    chk("t5_masked_events", n_lc_events, 0);
    chk("t5_masked_valid", 64'(evt_valid), 0);
    enable      = 1'b0;
    local_coinc = 24'h000001;
    tick(2);
    chk("t5_disabled_events", n_lc_events, 0);
    local_coinc = '0;
    tick(1);
    enable = 1'b1;
    tick(1);
    local_coinc = 24'h000001;
    push_exp(24'h000001, 16'd0);
    tick(1);
    chk("t5_reenable_trig", 64'(lc_trig), 1);
    chk("t5_reenable_mask", 64'(evt_mask), 64'h1);
    local_coinc = '0;
    chan_mask   = '1;
    tick(6);

    // 6a: asynchronous reset mid-holdoff with a pending record.
    do_reset();
    holdoff_len = 16'd20;
    evt_ready   = 1'b0;
    local_coinc = 24'h000001;
    tick(1);
    local_coinc = '0;
    tick(2);
    chk("t6_pre_busy", 64'(busy), 1);
    chk("t6_pre_valid", 64'(evt_valid), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async_lc_trig", 64'(lc_trig), 0);
    chk("t6_async_busy", 64'(busy), 0);
    chk("t6_async_valid", 64'(evt_valid), 0);
    chk("t6_async_mask", 64'(evt_mask), 0);
    chk("t6_async_seq", 64'(evt_seq), 0);
    chk("t6_async_events", n_lc_events, 0);
    chk("t6_async_dropped", n_lc_dropped, 0);
    sb.delete();
    tick(1);
    reset_n = 1'b1;
    tick(1);

    // 6b: counter saturation (2-bit instance sticks at 2'b11).
    holdoff_len = 16'd0;
    evt_ready   = 1'b0;
    pulse(24'h000001, 1'b1, 16'd0);
    for (int k = 1; k <= 4; k++) pulse(NC'(1) << k, 1'b0, 16'd0);
    chk("t6_dropped_full", n_lc_dropped, 4);
    chk("t6_dropped_sat", 64'(s_dropped), 3);
    chk("t6_sat_valid", 64'(s_evt_valid), 1);
    chk("t6_sat_mask", 64'(s_evt_mask), 64'h1);
    evt_ready = 1'b1;
    tick(1);
    for (int k = 1; k <= 4; k++) pulse(NC'(1) << (k + 8), 1'b1, 16'(k));
    chk("t6_events_full", n_lc_events, 5);
    chk("t6_events_sat", 64'(s_events), 3);
    chk("t6_sat_seq", 64'(s_evt_seq), 4);
    chk("t6_sat_idle", 64'({s_lc_trig, s_busy}), 0);
    tick(2);

    chk("sb_leftover", 64'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lc_trigger_gen.md
Name: lc_trigger_gen

Overview:
- Sits directly downstream of the local-coincidence stage and consumes its per-channel `local_coinc` vector.
- Turns each new coincidence into three things:
  - a single-cycle global LC trigger pulse;
  - an event record (channel mask plus sequence number) delivered to readout over a valid/ready handshake;
  - a programmable holdoff (deadtime) that suppresses retriggering.
- Keeps saturating counters of accepted and dropped LC events for slow control.

Parameters:
- N_CHANNELS, 24, number of coincidence channels.
- P_HOLDOFF_WIDTH, 16, width of the holdoff counter and of `holdoff_len`.
- P_CNT_WIDTH, 32, width of the event and drop counters.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- enable  input  1  when low, no new events are started.
- holdoff_len  input  P_HOLDOFF_WIDTH  deadtime in clk cycles after each qualifying edge.
- chan_mask  input  N_CHANNELS  1 = channel participates.
- local_coinc  input  N_CHANNELS  per-channel coincidence flags from the upstream stage.
- lc_trig  output  1  one-cycle pulse per accepted event.
- busy  output  1  high while in HOLDOFF.
- evt_valid  output  1  event record available.
- evt_ready  input  1  readout accepts the record.
- evt_mask  output  N_CHANNELS  masked `local_coinc` captured at the trigger edge.
- evt_seq  output  16  event sequence number, wraps.
- n_lc_events  output  P_CNT_WIDTH  accepted-event count, saturating.
- n_lc_dropped  output  P_CNT_WIDTH  dropped-event count, saturating.

Behaviour:
- Reset (async, `reset_n` low):
  - state = IDLE;
  - all outputs 0, including `lc_trig`, `busy`, `evt_valid`, `evt_mask`, `evt_seq`, both counters;
  - internal `any_prev` = 0 and the sequence counter = 0.
  - Reset mid-holdoff or with a pending record discards both.
- Combinational signals:
  - `masked = local_coinc & chan_mask`;
  - `any = |masked`.
- Edge register: `any_prev` is registered every cycle regardless of state.
- Qualifying edge at cycle t: `any & ~any_prev & enable & state==IDLE`.
- Slot free at cycle t: `!evt_valid | evt_ready`.
- Qualifying edge with slot free (accepted). At t+1:
  - `lc_trig` = 1 for exactly one cycle;
  - `evt_valid` = 1, `evt_mask` = `masked` sampled at t, `evt_seq` = sequence counter value;
  - sequence counter then increments (wraps 0xFFFF -> 0);
  - `n_lc_events` increments, saturating at all-ones;
  - state = HOLDOFF, counter loaded with `holdoff_len`.
- Qualifying edge with slot full (`evt_valid & !evt_ready`, dropped):
  - no `lc_trig` pulse, record unchanged, sequence counter unchanged;
  - `n_lc_dropped` increments, saturating;
  - state still enters HOLDOFF with `holdoff_len`.
- HOLDOFF state:
  - `busy` = 1;
  - counter decrements once per cycle; when counter == 0 the state returns to IDLE the next cycle;
  - `holdoff_len` = 0 therefore gives exactly one HOLDOFF cycle;
  - edges during HOLDOFF are ignored and not counted.
  - Because `any_prev` tracks continuously, a level held high through holdoff does not retrigger; `any` must fall and rise again.
- Record handshake:
  - the record is held stable while `evt_valid & !evt_ready`;
  - `evt_valid & evt_ready` at a cycle with no new accept clears `evt_valid` at the next edge;
  - simultaneous ready and new accept keeps `evt_valid` = 1 and loads the new record (back-to-back).
- `enable` low:
  - blocks new qualifying edges only;
  - an in-progress holdoff completes;
  - a pending record remains until consumed.
- `chan_mask` and `holdoff_len` are sampled live; `holdoff_len` is used only at load time.

Optional Feature: LC_TIMESTAMP_EN
- Defined:
  - adds input `timestamp` (48 bits, free-running, same clk);
  - adds output `evt_ts` (48 bits), captured from `timestamp` at cycle t of an accepted edge;
  - `evt_ts` follows the same handshake and stability rules as `evt_mask`;
  - `evt_ts` resets to 0.
- Undefined: both ports and the capture register are absent; all other behaviour is identical.

Decomposition:
- Package `lc_pkg`:
  - state type {IDLE, HOLDOFF};
  - constants `LC_SEQ_WIDTH` = 16 and `LC_TS_WIDTH` = 48;
  - saturating-increment function shared by both counters.
- One sub-module, `lc_holdoff_timer`:
  - inputs: `load`, `len`;
  - outputs: `busy`, `done`;
  - owns the down-counter and the IDLE/HOLDOFF state.
- Top level keeps edge detection, the record register, the handshake and the counters.

Test Plan:
1. Basic accept: `chan_mask` = all ones, `holdoff_len` = 4, `evt_ready` = 1; raise `local_coinc[3]` and `[7]` at t. Required:
   - `lc_trig` high only at t+1;
   - `evt_mask` = 0x000088, `evt_seq` = 0;
   - `busy` high for 5 cycles;
   - `n_lc_events` = 1.
2. Holdoff suppression: `holdoff_len` = 10; edge at t, second distinct edge at t+5, third at t+20. Required: events at t+1 and t+21 only, `evt_seq` 0 then 1, `n_lc_dropped` = 0.
3. Backpressure drop: `evt_ready` = 0, `holdoff_len` = 0; three separated edges. Required:
   - first record held stable (`evt_seq` = 0);
   - `n_lc_dropped` = 2, only one `lc_trig` pulse;
   - raising `evt_ready` for one cycle clears `evt_valid`.
4. Back-to-back handshake: `holdoff_len` = 0, `evt_ready` pulsed high in the same cycle as the second qualifying edge. Required: `evt_valid` stays 1, `evt_seq` advances 0 -> 1, no drop.
5. Masking and enable:
   - `chan_mask` = 0x000001 with only `local_coinc[5]` pulsing: no event;
   - `enable` = 0 with `local_coinc[0]` rising: no event;
   - re-enable, then a fresh edge on `local_coinc[0]`: event with `evt_mask` = 0x000001.
6. Reset and saturation:
   - assert `reset_n` low mid-HOLDOFF with `evt_valid` = 1: all outputs 0 immediately (asynchronously);
   - force `n_lc_dropped` to 0xFFFFFFFF via repeated drops (or preload in the bench), then drop again: value stays 0xFFFFFFFF.
